lcd_fb_reader: RTL and testbench

- Avalon-MM read master that scans a frame buffer held in the 32-bit single-port on-chip RAM.
- Serialises each fetched word into a byte stream with valid/ready handshake, feeding the LCD interface writer.
- Sits directly downstream of the on-chip memory and drives that memory's slave port (address, chipselect, write, byteenable, clken).
- Memory read latency is fixed at 1 cycle: address registered in RAM, output unregistered.

---
 rtl/lcd_fb_pkg.sv | 29 ++
 rtl/fb_word_fifo.sv | 79 +++++++
 rtl/lcd_fb_reader.sv | 198 +++++++++++++++++++
 tb/tb_lcd_fb_reader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_fb_pkg.sv
// Shared definitions for the LCD frame-buffer reader.
//   state_e         : scan controller states (IDLE, RUN, DRAIN)
//   BYTES_PER_WORD  : bytes serialised out of each 32-bit RAM word
//   MEM_RD_LATENCY  : cycles from chipselect to valid mem_readdata
//   DEF_MEM_WORDS   : default RAM depth in words
//   DEF_ADDR_W      : default word-address width
//   wrap_inc()      : address increment that wraps at the RAM depth
package lcd_fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int MEM_RD_LATENCY = 1;
  localparam int DEF_MEM_WORDS  = 51200;
  localparam int DEF_ADDR_W     = 16;

  // Next word address. Any address at or past the last word goes to 0, so an
  // out-of-range base is folded back into the RAM on its first increment.
  function automatic logic [31:0] wrap_inc(input logic [31:0] addr,
                                           input int unsigned words);
    if (addr >= 32'(words - 1)) return 32'd0;
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous word FIFO between the RAM read return and the byte serialiser.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : synchronous empty (scan abort); wins over push/pop
//   push, push_data : write a word
//   pop         : consume head word (only when head_valid)
//   head_valid, head_data : head word; falls through from push_data when empty
//   count       : stored words (a fall-through word is never counted)
module fb_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count_q == '0);
  // A word arriving into an empty FIFO that is popped in the same cycle goes
  // straight through without being stored.
  assign bypass     = empty && push && pop;
  assign do_push    = push && !bypass;
  assign do_pop     = pop && !empty;
  assign head_valid = !empty || push;
  assign head_data  = empty ? push_data : mem_q[rd_ptr_q];
  assign count      = count_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q guards every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/lcd_fb_reader.sv
// Frame-buffer scanner: reads word_count words from the on-chip RAM starting
// at base_addr and streams them out as little-endian bytes.
//   clk, reset          : clock (shared with RAM), synchronous active-high reset
//   start, abort        : one-cycle controls; abort wins over start
//   base_addr, word_count : frame geometry, sampled on accepted start
//   busy, done          : scan in progress / one-cycle completion pulse
//   mem_*               : Avalon-MM master to the RAM slave (read-only use)
//   out_data/valid/ready/last : byte stream to the LCD writer
module lcd_fb_reader
  import lcd_fb_pkg::*;
#(
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [15:0]               issued_q, issued_d;
  logic [15:0]               wc_q, wc_d;
  logic [15:0]               pop_cnt_q, pop_cnt_d;
  logic [MEM_RD_LATENCY-1:0] pend_q, pend_d;
  logic                      done_q, done_d;
  logic [31:0]               word_q, word_d;
  logic [1:0]                bidx_q, bidx_d;
  logic                      bvalid_q, bvalid_d;
  logic                      wlast_q, wlast_d;

  logic                      flush;
  logic                      rd_issue;
  logic [CNT_W:0]            occupancy;
  logic                      hs;
  logic                      byte3_hs;
  logic                      last_hs;
  logic                      pop;
  logic                      head_valid;
  logic [31:0]               head_data;
  logic [CNT_W-1:0]          fifo_count;

  assign busy  = (state_q != IDLE);
  assign flush = abort && busy;

  // Words already buffered plus reads still in flight must stay below the
  // FIFO depth, so a returning word always has a slot.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'($countones(pend_q));
  assign rd_issue  = (state_q == RUN) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  assign hs       = bvalid_q && out_ready;
  assign byte3_hs = hs && (bidx_q == LAST_BYTE);
  assign last_hs  = byte3_hs && wlast_q;
  assign pop      = (!bvalid_q || byte3_hs) && head_valid;

  fb_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (pend_q[MEM_RD_LATENCY-1]),
    .push_data  (mem_readdata),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  // Scan controller: state, address and word counters.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    issued_d  = issued_q;
    wc_d      = wc_q;
    pop_cnt_d = pop_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (word_count == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            addr_d    = base_addr;
            wc_d      = word_count;
            issued_d  = 16'd0;
            pop_cnt_d = 16'd0;
          end
        end
      end
      RUN: begin
        if (rd_issue) begin
          addr_d   = ADDR_W'(wrap_inc(32'(addr_q), MEM_WORDS));
          issued_d = issued_q + 16'd1;
          if (issued_q + 16'd1 == wc_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) pop_cnt_d = pop_cnt_q + 16'd1;
    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // Reads in flight; an abort drops the pending return.
  always_comb begin
    pend_d = flush ? '0 : MEM_RD_LATENCY'({pend_q, rd_issue});
  end

  // Byte serialiser: holds one word and walks its bytes low to high.
  always_comb begin
    word_d   = word_q;
    bidx_d   = bidx_q;
    bvalid_d = bvalid_q;
    wlast_d  = wlast_q;
    if (hs)       bidx_d   = bidx_q + 2'd1;
    if (byte3_hs) bvalid_d = 1'b0;
    if (pop) begin
      word_d   = head_data;
      bidx_d   = 2'd0;
      bvalid_d = 1'b1;
      wlast_d  = (pop_cnt_q == wc_q - 16'd1);
    end
    if (flush) begin
      bidx_d   = 2'd0;
      bvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      issued_q  <= '0;
      wc_q      <= '0;
      pop_cnt_q <= '0;
      pend_q    <= '0;
      done_q    <= 1'b0;
      word_q    <= '0;
      bidx_q    <= '0;
      bvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      wc_q      <= wc_d;
      pop_cnt_q <= pop_cnt_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      word_q    <= word_d;
      bidx_q    <= bidx_d;
      bvalid_q  <= bvalid_d;
      wlast_q   <= wlast_d;
    end
  end

  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = rd_issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign out_valid      = bvalid_q;
  assign out_data       = word_q[{bidx_q, 3'b000} +: 8];
  assign out_last       = bvalid_q && wlast_q && (bidx_q == LAST_BYTE);

endmodule

// File: tb/tb_lcd_fb_reader.sv
module tb_lcd_fb_reader;

  localparam int MEM_WORDS  = 51200;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       word_count = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;
  logic [7:0]        out_data;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;

  lcd_fb_reader #(
    .MEM_WORDS (MEM_WORDS), .ADDR_W (ADDR_W), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .base_addr (base_addr), .word_count (word_count),
    .busy (busy), .done (done),
    .mem_address (mem_address), .mem_chipselect (mem_chipselect),
    .mem_write (mem_write), .mem_byteenable (mem_byteenable),
    .mem_clken (mem_clken), .mem_readdata (mem_readdata),
    .out_data (out_data), .out_valid (out_valid),
    .out_ready (out_ready), .out_last (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM contents: two fixed words at 0/1, a hash of the address elsewhere.
  function automatic logic [31:0] ram_word(input int unsigned a);
    logic [31:0] v;
    if (a == 0) return 32'h4433_2211;
    if (a == 1) return 32'h8877_6655;
    v = a;
    return {v[15:0] ^ 16'hA5C3, 16'(v * 7 + 3)};
  endfunction

  // RAM with one-cycle read latency.
  logic [31:0] rd_q = '0;
  always @(posedge clk) if (mem_chipselect) rd_q <= ram_word(int'(mem_address));
  assign mem_readdata = rd_q;

  always @(posedge clk) cyc++;

  // ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
  int mode = 0;
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Behavioural model: word/byte counts, buffered-word count and pending read.
  bit          m_busy = 0, m_done = 0, m_bv = 0;
  int          m_pend = 0, m_fifo = 0, m_issued = 0, m_hs = 0, m_wc = 0;
  int unsigned m_base = 0;

  // Observation logs for directed checks.
  int          start_cyc = 0;
  int          hs_cyc[$];
  logic [7:0]  hs_dat[$];
  bit          hs_lst[$];
  int          cs_addr[$];
  int          done_cyc[$];

  function automatic int unsigned model_addr(input int k);
    return (m_base + k) % MEM_WORDS;
  endfunction

  always @(negedge clk) begin
    bit exp_cs, hs, byte3, last_hs, load;
    int avail;
    logic [31:0] w;
    exp_cs = m_busy && (m_issued < m_wc) && (m_fifo + m_pend < FIFO_DEPTH);
    if (cyc > 0) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("chipselect", mem_chipselect, exp_cs);
      check("out_valid", out_valid, m_bv);
      check("mem_write", mem_write, 1'b0);
      check("byteenable", mem_byteenable, 4'hF);
      check("clken", mem_clken, 1'b1);
      if (exp_cs) check("address", mem_address, model_addr(m_issued));
      if (m_bv) begin
        w = ram_word(model_addr(m_hs / 4));
        check("out_data", out_data, w[8*(m_hs%4) +: 8]);
        check("out_last", out_last, m_hs == 4 * m_wc - 1);
      end
    end
    if (start && !m_busy && !abort && !reset) start_cyc = cyc;
    if (out_valid && out_ready) begin
      hs_cyc.push_back(cyc); hs_dat.push_back(out_data); hs_lst.push_back(out_last);
    end
    if (mem_chipselect) cs_addr.push_back(int'(mem_address));
    if (done) done_cyc.push_back(cyc);

    hs      = m_bv && out_ready;
    byte3   = hs && (m_hs % 4 == 3);
    last_hs = hs && (m_hs == 4 * m_wc - 1);
    if (reset) begin
      m_busy = 0; m_done = 0; m_bv = 0; m_pend = 0; m_fifo = 0;
    end else if (abort) begin
      m_busy = 0; m_done = 0; m_bv = 0; m_pend = 0; m_fifo = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        if (word_count == 0) m_done = 1;
        else begin
          m_busy = 1; m_wc = int'(word_count); m_base = int'(base_addr);
          m_issued = 0; m_hs = 0;
        end
      end
    end else begin
      avail  = m_fifo + m_pend;
      load   = (!m_bv || byte3) && avail > 0;
      if (hs) m_hs++;
      m_fifo = avail - (load ? 1 : 0);
      if (load) m_bv = 1; else if (byte3) m_bv = 0;
      m_pend = exp_cs ? 1 : 0;
      if (exp_cs) m_issued++;
      m_done = last_hs;
      if (last_hs) m_busy = 0;
    end
  end

  task automatic clear_logs();
    hs_cyc.delete(); hs_dat.delete(); hs_lst.delete(); cs_addr.delete(); done_cyc.delete();
  endtask

  task automatic start_frame(input int unsigned b, input int unsigned n);
    @(posedge clk); #1;
    clear_logs();
    base_addr = ADDR_W'(b); word_count = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("done_timeout", got, 1'b1);
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (!busy) got = 1;
    end
    check("idle_timeout", got, 1'b1);
  endtask

  task automatic check_frame01(input string tag);
    logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check({tag, "_nbytes"}, hs_dat.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_byte"}, hs_dat[i], exp_b[i]);
      check({tag, "_last"}, hs_lst[i], i == 7);
    end
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_address", mem_address, 0);
    check("rst_out_data", out_data, 0);

    // Frame of RAM[0..1] at full rate.
    mode = 0;
    start_frame(0, 2);
    wait_done(100);
    check_frame01("full");
    for (int i = 0; i < 8; i++) check("full_cycle", hs_cyc[i] - start_cyc, 3 + i);
    check("full_done_cycle", done_cyc[0] - start_cyc, 11);
    repeat (3) @(negedge clk); #1;
    check("full_done_count", done_cyc.size(), 1);
    check("full_busy_after", busy, 1'b0);

    // Same frame under a stalling consumer.
    mode = 1;
    start_frame(0, 2);
    wait_done(200);
    check_frame01("stall");
    mode = 0;

    // Address wrap at the top of the RAM.
    start_frame(MEM_WORDS - 1, 3);
    wait_done(100);
    check("wrap_ncs", cs_addr.size(), 3);
    check("wrap_addr0", cs_addr[0], MEM_WORDS - 1);
    check("wrap_addr1", cs_addr[1], 0);
    check("wrap_addr2", cs_addr[2], 1);
    check("wrap_byte4", hs_dat[4], 8'h11);
    check("wrap_byte8", hs_dat[8], 8'h55);

    // Zero-length frame.
    start_frame(5, 0);
    repeat (5) @(negedge clk); #1;
    check("zero_done_count", done_cyc.size(), 1);
    check("zero_done_cycle", done_cyc[0] - start_cyc, 1);
    check("zero_ncs", cs_addr.size(), 0);

    // Abort mid-frame, then a clean one-word frame.
    start_frame(0, 4);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (hs_dat.size() >= 5) got = 1;
    end
    check("abort_wait", got, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cs", mem_chipselect, 1'b0);
    repeat (3) @(negedge clk); #1;
    check("abort_no_done", done_cyc.size(), 0);
    start_frame(0, 1);
    wait_done(100);
    check("post_abort_n", hs_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("post_abort_byte", hs_dat[i], 8'h11 * (i + 1));
      check("post_abort_last", hs_lst[i], i == 3);
    end

    // Abort together with start while busy, and abort while idle.
    start_frame(40, 5);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk); #1;
    check("abort_start_busy", busy, 1'b0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;

    // Reset in the middle of a scan, then a power-up-like frame.
    mode = 2;
    start_frame(100, 6);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_cs", mem_chipselect, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_data", out_data, 0);
    mode = 0;
    start_frame(0, 2);
    wait_done(100);
    check_frame01("post_rst");
    check("post_rst_first", hs_cyc[0] - start_cyc, 3);

    // Randomised frames with random back-pressure, stray starts and aborts.
    mode = 2;
    for (int f = 0; f < 30; f++) begin
      int unsigned b;
      int unsigned n;
      int kind;
      b    = ($urandom_range(0, 3) == 0) ? $urandom_range(MEM_WORDS - 4, MEM_WORDS - 1)
                                         : $urandom_range(0, MEM_WORDS - 1);
      n    = $urandom_range(1, 10);
      kind = $urandom_range(0, 4);
      start_frame(b, n);
      if (kind == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle(50);
      end else begin
        if (kind == 1) begin
          repeat (3) @(posedge clk);
          #1 base_addr = ADDR_W'($urandom); word_count = 16'($urandom_range(1, 100)); start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
        wait_done(600);
      end
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
